// File: rtl/v_sv_resp.sv
// ------------------------------------------------------------------------
// v_sv_resp : single-outstanding request/response register-file responder.
// Optional request parity checking is enabled by V_SV_RESP_PARITY_EN.
// Revision  : 1.0
// ------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module v_sv_resp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [7:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_par,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       txn_count
);

  localparam logic [8:0] NREGS_L = 9'(NREGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              req_fire;
  logic              rsp_fire;
  logic              cap_write;
  logic [7:0]        cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              addr_bad;
  logic              par_bad;
  logic              acc_err;
  logic              wr_en;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // req_ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_write <= 1'b0;
      cap_addr  <= 8'd0;
      cap_wdata <= '0;
    end else if (req_fire) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

`ifdef V_SV_RESP_PARITY_EN
  logic cap_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_par <= 1'b0;
    end else if (req_fire) begin
      cap_par <= req_par;
    end
  end

  // Even parity: the XOR over payload plus parity bit must be zero.
  assign par_bad = ^{cap_write, cap_addr, cap_wdata, cap_par};
`else
  logic unused_par;

  assign unused_par = req_par;
  assign par_bad    = 1'b0;
`endif

  assign addr_bad = {1'b0, cap_addr} >= NREGS_L;
  assign acc_err  = addr_bad || par_bad;
  assign wr_en    = (state == ACCESS) && cap_write && !acc_err;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (cap_addr == 8'(i)) begin
        rd_mux = regs[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en && (cap_addr == 8'(i))) begin
          regs[i] <= cap_wdata;
        end
      end
    end
  end

  // Response fields are loaded once in ACCESS and then held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      txn_count <= 16'd0;
    end else begin
      if (state == ACCESS) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || cap_write) ? '0 : rd_mux;
      end else if (rsp_fire) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
      if (rsp_fire) begin
        txn_count <= txn_count + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
